// File: rtl/switch_debouncer.sv
// Per-bit 2-FF synchroniser plus stability-counter debounce for slide switches.
// SWITCH and the edge strobes update STABLE_COUNT+2 edges after the first edge that samples a new raw level.
module switch_debouncer #(
    parameter int N            = 5,
    parameter int STABLE_COUNT = 1000000,
    parameter int CNT_W        = 20
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [N-1:0] SW_RAW,
    output logic [N-1:0] SWITCH,
    output logic [N-1:0] EDGE_RISE,
    output logic [N-1:0] EDGE_FALL,
    output logic         CHANGED
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_COUNT - 1);

    logic [N-1:0]     s1;
    logic [N-1:0]     s2;
    logic [N-1:0]     flip;
    logic [CNT_W-1:0] cnt [N];

    // A bit flips on the sample that completes STABLE_COUNT consecutive disagreements.
    always_comb begin
        flip = '0;
        for (int i = 0; i < N; i++) begin
            flip[i] = (s2[i] != SWITCH[i]) && (cnt[i] == LAST);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1        <= '0;
            s2        <= '0;
            SWITCH    <= '0;
            EDGE_RISE <= '0;
            EDGE_FALL <= '0;
            CHANGED   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1        <= SW_RAW;
            s2        <= s1;
            SWITCH    <= SWITCH ^ flip;
            EDGE_RISE <= flip & s2;
            EDGE_FALL <= flip & ~s2;
            CHANGED   <= |flip;
            // Any agreeing sample restarts the count, which rejects glitches.
            for (int i = 0; i < N; i++) begin
                if ((s2[i] == SWITCH[i]) || flip[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_COUNT=4: per-edge vector table plus reset corner cases.
module tb_switch_debouncer;

    logic       CLK;
    logic       RST_N;
    logic [4:0] SW_RAW;
    logic [4:0] SWITCH;
    logic [4:0] EDGE_RISE;
    logic [4:0] EDGE_FALL;
    logic       CHANGED;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0] raw;
        logic [4:0] sw;
        logic [4:0] rise;
        logic [4:0] fall;
        logic       ch;
    } vec_t;

    vec_t tbl[$];

    switch_debouncer #(.N(5), .STABLE_COUNT(4), .CNT_W(3)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .SW_RAW    (SW_RAW),
        .SWITCH    (SWITCH),
        .EDGE_RISE (EDGE_RISE),
        .EDGE_FALL (EDGE_FALL),
        .CHANGED   (CHANGED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [4:0] sw, input logic [4:0] rise,
                         input logic [4:0] fall, input logic ch);
        checks++;
        if ({SWITCH, EDGE_RISE, EDGE_FALL, CHANGED} !== {sw, rise, fall, ch}) begin
            errors++;
            $display("FAIL %s: got sw=%b rise=%b fall=%b chg=%b, expected sw=%b rise=%b fall=%b chg=%b",
                     name, SWITCH, EDGE_RISE, EDGE_FALL, CHANGED, sw, rise, fall, ch);
        end
    endtask

    task automatic add(input logic [4:0] raw, input logic [4:0] sw, input logic [4:0] rise,
                       input logic [4:0] fall, input logic ch);
        vec_t v;
        v.raw = raw; v.sw = sw; v.rise = rise; v.fall = fall; v.ch = ch;
        tbl.push_back(v);
    endtask

    task automatic add_quiet(input int n, input logic [4:0] raw, input logic [4:0] sw);
        for (int i = 0; i < n; i++) add(raw, sw, 5'b0, 5'b0, 1'b0);
    endtask

    // New raw level sampled at the first row; the flip is visible after the sixth edge.
    task automatic add_flip(input logic [4:0] from, input logic [4:0] to);
        add_quiet(5, to, from);
        add(to, to, to & ~from, from & ~to, 1'b1);
        add_quiet(1, to, to);
    endtask

    initial begin
        RST_N  = 1'b0;
        SW_RAW = 5'b11111;

        // Power-up: all switches up, all bits come up together.
        add_flip(5'b00000, 5'b11111);
        add_flip(5'b11111, 5'b00000);
        // Clean press and release of bit 2.
        add_flip(5'b00000, 5'b00100);
        add_flip(5'b00100, 5'b00000);
        // Bounce on bit 0, then held high.
        add(5'b00001, 5'b0, 5'b0, 5'b0, 1'b0);
        add(5'b00000, 5'b0, 5'b0, 5'b0, 1'b0);
        add(5'b00001, 5'b0, 5'b0, 5'b0, 1'b0);
        add(5'b00000, 5'b0, 5'b0, 5'b0, 1'b0);
        add_flip(5'b00000, 5'b00001);
        add_flip(5'b00001, 5'b00000);
        // 3-cycle glitch on bit 4 is rejected.
        add_quiet(3, 5'b10000, 5'b00000);
        add_quiet(4, 5'b00000, 5'b00000);
        // 8-cycle pulse on bit 4 gives a rise and then a fall.
        add_quiet(5, 5'b10000, 5'b00000);
        add(5'b10000, 5'b10000, 5'b10000, 5'b0, 1'b1);
        add_quiet(2, 5'b10000, 5'b10000);
        add_flip(5'b10000, 5'b00000);
        // Several bits at once.
        add_flip(5'b00000, 5'b10011);
        add_flip(5'b10011, 5'b00000);

        repeat (3) @(posedge CLK);
        #1 check("reset_hold", 5'b0, 5'b0, 5'b0, 1'b0);

        @(posedge CLK);
        #1 RST_N = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            SW_RAW = tbl[i].raw;
            @(posedge CLK);
            #1 check($sformatf("row%0d", i), tbl[i].sw, tbl[i].rise, tbl[i].fall, tbl[i].ch);
        end

        // Asynchronous reset while bit 1 is part-way through its count.
        @(negedge CLK);
        SW_RAW = 5'b00001;
        repeat (8) @(posedge CLK);
        #1 check("pre_reset_bit0", 5'b00001, 5'b0, 5'b0, 1'b0);
        @(negedge CLK);
        SW_RAW = 5'b00011;
        repeat (4) @(posedge CLK);
        #1 check("mid_count", 5'b00001, 5'b0, 5'b0, 1'b0);
        @(negedge CLK);
        RST_N = 1'b0;
        #1 check("async_clear", 5'b0, 5'b0, 5'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge CLK);
            #1;
            if (e < 6)
                check($sformatf("rerun_edge%0d", e), 5'b0, 5'b0, 5'b0, 1'b0);
            else if (e == 6)
                check("rerun_flip", 5'b00011, 5'b00011, 5'b0, 1'b1);
            else
                check("rerun_after", 5'b00011, 5'b0, 5'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
